pipelined_adder: RTL and testbench



---
 rtl/pipelined_adder_pkg.sv | 27 ++
 rtl/pipelined_adder_segment.sv | 37 +++
 rtl/pipelined_adder.sv | 193 +++++++++++++++++++
 tb/tb_pipelined_adder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipelined_adder_pkg
//  Purpose  : Shared constants and helpers for the segmented pipelined adder.
//             - c_default_width / c_default_seg_width : default geometry
//             - calc_stages()  : pipeline depth (one carry segment per stage)
//             - width_ok()     : geometry legality, used as an elaboration check
//  Macro    : PIPELINED_ADDER_SUB_EN (consumed by pipelined_adder only)
//  Revision : 1.0  initial release
// ============================================================================
package pipelined_adder_pkg;

    localparam int c_default_width     = 16;
    localparam int c_default_seg_width = 4;

    // Number of pipeline stages: each stage resolves exactly one segment.
    function automatic int calc_stages(input int width, input int seg_width);
        return width / seg_width;
    endfunction

    // The operand must split into a whole number of non-empty segments.
    function automatic bit width_ok(input int width, input int seg_width);
        return (seg_width > 0) && (width >= seg_width) && ((width % seg_width) == 0);
    endfunction

endpackage : pipelined_adder_pkg
`default_nettype wire

// File: rtl/pipelined_adder_segment.sv
`default_nettype none
// ============================================================================
//  Module   : adder_segment
//  Purpose  : Combinational SEG_WIDTH-bit ripple adder with carry-in.
//  Ports    : a, b   [SEG_WIDTH-1:0]  segment operands
//             cin                     carry into bit 0
//             sum    [SEG_WIDTH-1:0]  segment sum
//             cout                    carry out of the segment MSB
//             c_msb                   carry into the segment MSB (for ovf)
//  Revision : 1.0  initial release
// ============================================================================
module adder_segment
    import pipelined_adder_pkg::*;
#(
    parameter int SEG_WIDTH = c_default_seg_width
) (
    input  logic [SEG_WIDTH-1:0] a,
    input  logic [SEG_WIDTH-1:0] b,
    input  logic                 cin,
    output logic [SEG_WIDTH-1:0] sum,
    output logic                 cout,
    output logic                 c_msb
);

    logic [SEG_WIDTH:0] w_total;

    // One extra bit captures the carry out of the segment.
    assign w_total = {1'b0, a} + {1'b0, b} + {{SEG_WIDTH{1'b0}}, cin};
    assign sum     = w_total[SEG_WIDTH-1:0];
    assign cout    = w_total[SEG_WIDTH];

    // The MSB sum bit is a^b^carry_in, so the carry into the MSB is recovered
    // by stripping the operand bits back out.
    assign c_msb   = sum[SEG_WIDTH-1] ^ a[SEG_WIDTH-1] ^ b[SEG_WIDTH-1];

endmodule : adder_segment
`default_nettype wire

// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
//  Module   : pipelined_adder
//  Purpose  : Pipelined ripple-carry adder. The WIDTH-bit carry chain is cut
//             into SEG_WIDTH-bit segments, one segment resolved per stage, with
//             a valid/ready handshake on input and output. One op per cycle.
//  Ports    : clk, rst            clock, synchronous active-high reset
//             in_valid / in_ready input handshake
//             a, b [WIDTH-1:0]    operands
//             cin                 carry-in
//             sub                 subtract select (only with the macro below)
//             out_valid/out_ready output handshake
//             sum [WIDTH-1:0]     a+b+cin mod 2^WIDTH
//             cout                carry out of MSB (borrow when subtracting)
//             ovf                 signed overflow (carry into MSB ^ carry out)
//  Macro    : PIPELINED_ADDER_SUB_EN  adds the 'sub' port and subtract mode.
//  Revision : 1.0  initial release
// ============================================================================
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH     = c_default_width,
    parameter int SEG_WIDTH = c_default_seg_width
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef PIPELINED_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = calc_stages(WIDTH, SEG_WIDTH);

    if (!width_ok(WIDTH, SEG_WIDTH)) begin : g_width_check
        $error("pipelined_adder: WIDTH must be a non-zero multiple of SEG_WIDTH");
    end

    // ------------------------------------------------------------------------
    // Global pipeline enable: the only thing that can hold the pipe is a valid
    // result that downstream refuses. A bubble at the output never stalls.
    // ------------------------------------------------------------------------
    logic w_stall;
    logic w_advance;

    assign w_stall   = out_valid & ~out_ready;
    assign w_advance = ~w_stall;
    assign in_ready  = ~w_stall;

    // ------------------------------------------------------------------------
    // Stage-0 operand conditioning. Subtraction is a + ~b + ~cin, so a borrow
    // request (cin=1) becomes a zero carry into the chain.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin_eff;
    logic             w_sub_eff;

`ifdef PIPELINED_ADDER_SUB_EN
    assign w_b_eff   = sub ? ~b : b;
    assign w_cin_eff = cin ^ sub;
    assign w_sub_eff = sub;
`else
    assign w_b_eff   = b;
    assign w_cin_eff = cin;
    assign w_sub_eff = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Stage k consumes the lowest remaining operand segment, appends its sum
    // above the partial sum of earlier stages, and forwards only the operand
    // segments not yet consumed.
    // ------------------------------------------------------------------------
    genvar k;
    for (k = 0; k < STAGES; k++) begin : g_stage
        localparam int c_rem  = WIDTH - (SEG_WIDTH * k);   // operand bits still unresolved at input
        localparam int c_done = SEG_WIDTH * (k + 1);       // sum bits resolved after this stage

        logic [c_rem-1:0]     w_a_in;
        logic [c_rem-1:0]     w_b_in;
        logic                 w_c_in;
        logic                 w_v_in;
        logic                 w_sub_in;
        logic [c_done-1:0]    w_psum_next;
        logic [SEG_WIDTH-1:0] w_seg_sum;
        logic                 w_seg_cout;
        logic                 w_seg_cmsb;
        logic                 w_load;

        logic                 r_valid;
        logic [c_done-1:0]    r_psum;

        if (k == 0) begin : g_src_port
            assign w_a_in      = a;
            assign w_b_in      = w_b_eff;
            assign w_c_in      = w_cin_eff;
            assign w_v_in      = in_valid;
            assign w_sub_in    = w_sub_eff;
            assign w_psum_next = w_seg_sum;
        end else begin : g_src_prev
            assign w_a_in      = g_stage[k-1].g_mid.r_a_up;
            assign w_b_in      = g_stage[k-1].g_mid.r_b_up;
            assign w_c_in      = g_stage[k-1].g_mid.r_carry;
            assign w_v_in      = g_stage[k-1].r_valid;
            assign w_sub_in    = g_stage[k-1].g_mid.r_sub;
            assign w_psum_next = {w_seg_sum, g_stage[k-1].r_psum};
        end

        adder_segment #(
            .SEG_WIDTH (SEG_WIDTH)
        ) u_seg (
            .a     (w_a_in[SEG_WIDTH-1:0]),
            .b     (w_b_in[SEG_WIDTH-1:0]),
            .cin   (w_c_in),
            .sum   (w_seg_sum),
            .cout  (w_seg_cout),
            .c_msb (w_seg_cmsb)
        );

        // Data registers load only behind a valid op, so a bubble moving
        // through leaves the previously delivered result visible on sum/cout/ovf.
        assign w_load = w_advance & w_v_in;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_psum  <= '0;
            end else begin
                if (w_advance) begin
                    r_valid <= w_v_in;
                end
                if (w_load) begin
                    r_psum <= w_psum_next;
                end
            end
        end

        if (k < STAGES - 1) begin : g_mid
            logic [c_rem-SEG_WIDTH-1:0] r_a_up;
            logic [c_rem-SEG_WIDTH-1:0] r_b_up;
            logic                       r_carry;
            logic                       r_sub;
            // Only the top segment's carry-into-MSB contributes to ovf.
            logic                       w_unused_cmsb;

            assign w_unused_cmsb = w_seg_cmsb;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_a_up  <= '0;
                    r_b_up  <= '0;
                    r_carry <= 1'b0;
                    r_sub   <= 1'b0;
                end else if (w_load) begin
                    r_a_up  <= w_a_in[c_rem-1:SEG_WIDTH];
                    r_b_up  <= w_b_in[c_rem-1:SEG_WIDTH];
                    r_carry <= w_seg_cout;
                    r_sub   <= w_sub_in;
                end
            end
        end else begin : g_last
            logic r_cout;
            logic r_ovf;

            // For subtraction the raw carry is "no borrow", so flip it to
            // report borrow. Overflow uses the raw internal carries.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cout <= 1'b0;
                    r_ovf  <= 1'b0;
                end else if (w_load) begin
                    r_cout <= w_seg_cout ^ w_sub_in;
                    r_ovf  <= w_seg_cout ^ w_seg_cmsb;
                end
            end

            assign out_valid = r_valid;
            assign sum       = r_psum;
            assign cout      = r_cout;
            assign ovf       = r_ovf;
        end
    end

endmodule : pipelined_adder
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipelined_adder
//  Purpose  : Self-checking bench for pipelined_adder (WIDTH=16, SEG_WIDTH=4).
//             A queue-based reference model predicts every output each cycle;
//             directed vectors also pin hand-computed results at fixed cycles.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipelined_adder;

    localparam int STAGES = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    always #5 clk = ~clk;

    pipelined_adder #(
        .WIDTH     (16),
        .SEG_WIDTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef PIPELINED_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    int checks   = 0;
    int failures = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
        int          age;   // clock edges since acceptance (enabled edges only)
    } ent_t;

    ent_t q[$];
    logic [15:0] last_s = '0;
    logic        last_c = 1'b0;
    logic        last_o = 1'b0;
    bit          chk_en = 1'b0;
    bit          exp_v;

    // a + b + cin, or a - b - cin when subtracting; plain integer arithmetic.
    function automatic ent_t model_op(input logic [15:0] aa, input logic [15:0] bb,
                                      input logic cc, input logic ss);
        ent_t e;
        int sa, sb, ua, ub, ci, r, u;
        sa = $signed(aa);
        sb = $signed(bb);
        ua = aa;
        ub = bb;
        ci = cc ? 1 : 0;
        if (ss) begin
            r   = sa - sb - ci;
            u   = ua - ub - ci;
            e.c = (ua < ub + ci);
        end else begin
            r   = sa + sb + ci;
            u   = ua + ub + ci;
            e.c = (u > 65535);
        end
        e.s   = u[15:0];
        e.o   = (r < -32768) || (r > 32767);
        e.age = 1;
        return e;
    endfunction

    // Compare every cycle, then advance the model to the coming rising edge.
    always @(negedge clk) begin
        exp_v = (q.size() > 0) && (q[0].age >= STAGES);
        if (chk_en) begin
            cmp("mon_out_valid", {31'd0, out_valid}, {31'd0, exp_v});
            cmp("mon_in_ready", {31'd0, in_ready}, {31'd0, !(exp_v && !out_ready)});
            if (exp_v) begin
                cmp("mon_sum", {16'd0, sum}, {16'd0, q[0].s});
                cmp("mon_cout", {31'd0, cout}, {31'd0, q[0].c});
                cmp("mon_ovf", {31'd0, ovf}, {31'd0, q[0].o});
                last_s = q[0].s;
                last_c = q[0].c;
                last_o = q[0].o;
            end else begin
                cmp("mon_hold", {13'd0, sum, cout, ovf}, {13'd0, last_s, last_c, last_o});
            end
        end
        if (rst) begin
            q.delete();
            last_s = '0;
            last_c = 1'b0;
            last_o = 1'b0;
        end else if (!(exp_v && !out_ready)) begin
            if (exp_v) void'(q.pop_front());
            foreach (q[i]) q[i].age = q[i].age + 1;
            if (in_valid) q.push_back(model_op(a, b, cin, sub));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] aa, input logic [15:0] bb,
                         input logic cc, input logic ss);
        in_valid = v;
        a        = aa;
        b        = bb;
        cin      = cc;
        sub      = ss;
    endtask

    task automatic idle_cycles(input int n);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        repeat (n) step();
    endtask

    // Pins {out_valid, sum, cout, ovf} at the current negedge against a literal.
    task automatic check_out(input string name, input logic v, input logic [15:0] s,
                             input logic c, input logic o);
        @(negedge clk);
        cmp(name, {13'd0, out_valid, sum, cout, ovf}, {13'd0, v, s, c, o});
        step();
    endtask

    bit          acc;
    bit          pend;
    int          idx;
    logic [15:0] ra, rb;
    logic        rc, rs;

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        step();
        step();
        rst    = 1'b0;
        chk_en = 1'b1;

        // Reset state
        @(negedge clk);
        cmp("reset_outputs", {13'd0, out_valid, sum, cout, ovf}, 32'd0);
        cmp("reset_in_ready", {31'd0, in_ready}, 32'd1);
        step();

        // Carry ripple through every segment
        drive(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        step();
        idle_cycles(3);
        check_out("ripple", 1'b1, 16'h0000, 1'b1, 1'b0);
        idle_cycles(4);

        // Signed overflow, both directions
        drive(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        step();
        drive(1'b1, 16'h8000, 16'h8000, 1'b0, 1'b0);
        step();
        idle_cycles(2);
        check_out("ovf_pos", 1'b1, 16'h8000, 1'b0, 1'b1);
        check_out("ovf_neg", 1'b1, 16'h0000, 1'b1, 1'b1);
        idle_cycles(4);

        // Streaming 8 back-to-back ops
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 16'(i), 16'(16'h1000 * i), i[0], 1'b0);
            step();
        end
        idle_cycles(3);
        check_out("stream_last", 1'b1, 16'h7008, 1'b0, 1'b0);
        idle_cycles(4);

        // Backpressure: out_ready low in cycles 5..7
        idx = 0;
        for (int c = 0; c < 16; c++) begin
            out_ready = !(c >= 5 && c <= 7);
            if (idx < 6) drive(1'b1, 16'(16'h1111 * idx), 16'h0F0F, 1'b1, 1'b0);
            else         drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
            @(negedge clk);
            if (c == 6) begin
                cmp("bp_held", {13'd0, out_valid, sum, cout, ovf}, {13'd0, 1'b1, 16'h2021, 1'b0, 1'b0});
                cmp("bp_in_ready", {31'd0, in_ready}, 32'd0);
            end
            acc = in_valid && in_ready;
            step();
            if (acc) idx++;
        end
        out_ready = 1'b1;
        idle_cycles(4);

        // Reset mid-flight
        drive(1'b1, 16'h0101, 16'h0202, 1'b0, 1'b0);
        step();
        drive(1'b1, 16'h0F00, 16'h0100, 1'b1, 1'b0);
        step();
        rst = 1'b1;
        drive(1'b1, 16'hAAAA, 16'h5555, 1'b1, 1'b0);
        step();
        rst = 1'b0;
        drive(1'b1, 16'h1234, 16'h4321, 1'b1, 1'b0);
        step();
        idle_cycles(2);
        check_out("rst_no_stale", 1'b0, 16'h0000, 1'b0, 1'b0);
        check_out("rst_post_op", 1'b1, 16'h5556, 1'b0, 1'b0);
        idle_cycles(4);

`ifdef PIPELINED_ADDER_SUB_EN
        // Subtraction with borrow, and signed overflow on subtract
        drive(1'b1, 16'h0005, 16'h0007, 1'b0, 1'b1);
        step();
        drive(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1);
        step();
        idle_cycles(2);
        check_out("sub_borrow", 1'b1, 16'hFFFE, 1'b1, 1'b0);
        check_out("sub_ovf", 1'b1, 16'h7FFF, 1'b0, 1'b1);
        idle_cycles(4);
`endif

        // Random traffic with random backpressure, model-checked every cycle
        pend = 1'b0;
        ra = '0; rb = '0; rc = 1'b0; rs = 1'b0;
        for (int c = 0; c < 200; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!pend && ($urandom_range(0, 9) < 7)) begin
                ra   = 16'($urandom);
                rb   = 16'($urandom);
                rc   = 1'($urandom_range(0, 1));
`ifdef PIPELINED_ADDER_SUB_EN
                rs   = 1'($urandom_range(0, 1));
`endif
                pend = 1'b1;
            end
            if (pend) drive(1'b1, ra, rb, rc, rs);
            else      drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
            @(negedge clk);
            acc = in_valid && in_ready;
            step();
            if (acc) pend = 1'b0;
        end
        out_ready = 1'b1;
        idle_cycles(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pipelined_adder
`default_nettype wire
